// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback stage.
package wb_pkg;
   typedef enum logic [1:0] {SEL_ALU, SEL_MEM, SEL_LINK, SEL_RSVD} sel_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
   typedef enum logic {IDLE, WAIT_MEM} state_e;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: little-endian lane select plus zero/sign extension of a raw memory word.
module wb_load_align
   import wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int AW     = $clog2(DATA_W/8)
) (
   input  size_e             size,
   input  logic              sgn,
   input  logic [AW-1:0]     addr_lo,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] data
);
   logic [AW-1:0] ofs;
   logic [7:0] sa;
   logic [DATA_W-1:0] sh, up;
   logic signed [DATA_W-1:0] sx;
   always_comb begin
      ofs = size == SZ_B ? addr_lo :
            size == SZ_H ? {addr_lo[AW-1:1], 1'b0} :
            (size == SZ_W && DATA_W == 64) ? {addr_lo[AW-1], {(AW-1){1'b0}}} : '0;
      sa  = size == SZ_B ? 8'(DATA_W-8) :
            size == SZ_H ? 8'(DATA_W-16) :
            (size == SZ_W && DATA_W == 64) ? 8'(DATA_W-32) : 8'd0;
      sh  = rdata >> {ofs, 3'b000};
      // push the lane to the top, then shift back down to extend
      up  = sh << sa;
      sx  = $signed(up) >>> sa;
      data = sgn ? sx : up >> sa;
   end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage selecting ALU, aligned load or link data into the register file.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W   = 16,
   parameter int REG_AW = 5,
   parameter int PC_INC = 2,
   parameter int CNT_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [PC_W-1:0]             in_pc,
   input  logic [DATA_W-1:0]           in_alu_res,
   input  logic [REG_AW-1:0]           in_rd,
   input  logic                        in_reg_write,
   input  logic [1:0]                  in_sel,
   input  logic [1:0]                  in_mem_size,
   input  logic                        in_mem_signed,
   input  logic [$clog2(DATA_W/8)-1:0] in_addr_lo,
   input  logic                        mem_rvalid,
   input  logic [DATA_W-1:0]           mem_rdata,
   input  logic                        flush,
   output logic                        rf_we,
   output logic [REG_AW-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   output logic [PC_W-1:0]             pc_out,
   output logic                        wb_valid,
   output logic                        fwd_valid,
   output logic [REG_AW-1:0]           fwd_rd,
   output logic [DATA_W-1:0]           fwd_data,
   output logic [CNT_W-1:0]            stall_cnt
);
   localparam int AW = $clog2(DATA_W/8);
   state_e state, state_n;
   logic [REG_AW-1:0] l_rd, ret_rd;
   logic [PC_W-1:0] l_pc, ret_pc;
   size_e l_size;
   logic l_sgn, l_rw, acc, ret, ret_we;
   logic [AW-1:0] l_addr;
   logic [DATA_W-1:0] ld_data, ret_data;
   assign in_ready  = state == IDLE;
   assign acc       = in_ready && in_valid && !flush;
   assign fwd_valid = rf_we;
   assign fwd_rd    = rf_waddr;
   assign fwd_data  = rf_wdata;
   wb_load_align #(.DATA_W(DATA_W)) u_align (
      .size(l_size), .sgn(l_sgn), .addr_lo(l_addr), .rdata(mem_rdata), .data(ld_data)
   );
   always_comb begin
      state_n  = state;
      ret      = 1'b0;
      ret_we   = 1'b0;
      ret_pc   = in_pc;
      ret_rd   = in_rd;
      ret_data = in_alu_res;
      if (state == IDLE) begin
         if (acc && in_sel == SEL_MEM) state_n = WAIT_MEM;
         else if (acc) begin
            ret      = 1'b1;
            ret_we   = in_reg_write && in_rd != '0 && in_sel != SEL_RSVD;
            ret_data = in_sel == SEL_LINK ? DATA_W'(PC_W'(in_pc + PC_W'(PC_INC))) : in_alu_res;
         end
      end else if (flush) state_n = IDLE;
      else if (mem_rvalid) begin
         state_n  = IDLE;
         ret      = 1'b1;
         ret_we   = l_rw && l_rd != '0;
         ret_pc   = l_pc;
         ret_rd   = l_rd;
         ret_data = ld_data;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         l_rd      <= '0;
         l_pc      <= '0;
         l_size    <= SZ_B;
         l_sgn     <= 1'b0;
         l_rw      <= 1'b0;
         l_addr    <= '0;
         rf_we     <= 1'b0;
         wb_valid  <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         pc_out    <= '0;
         stall_cnt <= '0;
      end else begin
         state    <= state_n;
         rf_we    <= ret_we;
         wb_valid <= ret;
         if (ret) pc_out <= ret_pc;
         if (ret_we) begin
            rf_waddr <= ret_rd;
            rf_wdata <= ret_data;
         end
         if (acc) begin
            l_rd   <= in_rd;
            l_pc   <= in_pc;
            l_size <= size_e'(in_mem_size);
            l_sgn  <= in_mem_signed;
            l_rw   <= in_reg_write;
            l_addr <= in_addr_lo;
         end
         if (state == WAIT_MEM && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end
endmodule
